// File: rtl/cc_gate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cc_gate_pkg
// Description : Shared types and helpers for the sequential condition-code
//               channel gate: FSM state encoding, command record and the
//               broadcast-mode decode.
// Revision    : 1.0 - initial release
// ============================================================================
package cc_gate_pkg;

    // Upper bounds for the command record fields. Instances narrower than
    // these zero-extend into the record.
    localparam int CC_MAX_NCH = 32;
    localparam int CC_MAX_CW  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } cc_gate_state_e;

    typedef struct packed {
        logic                  sel_i;
        logic                  sel_k;
        logic                  dir;
        logic [CC_MAX_NCH-1:0] mask;
        logic [CC_MAX_CW-1:0]  beats;
    } cc_gate_cmd_t;

    // Broadcast mode: both selects set with the direction bit clear.
    function automatic logic cc_bcast(input logic sel_i, input logic sel_k,
                                      input logic dir);
        return sel_i & sel_k & ~dir;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cc_gate_lane.sv
`default_nettype none
// ============================================================================
// Module      : cc_gate_lane
// Description : Combinational gate for a single channel lane. In broadcast
//               mode the lane is forced to the replicated mask bit, otherwise
//               the live channel data passes through.
//               Optional feature macro: CC_GATE_PARITY_EN (adds lane parity).
// Ports       : bcast    - broadcast mode active
//               mask_bit - force value for this lane
//               data     - live W-bit lane input
//               lane     - gated W-bit lane value
//               par      - even parity of lane (CC_GATE_PARITY_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module cc_gate_lane #(
    parameter int W = 1
) (
    input  logic         bcast,
    input  logic         mask_bit,
    input  logic [W-1:0] data,
`ifdef CC_GATE_PARITY_EN
    output logic         par,
`endif
    output logic [W-1:0] lane
);

    assign lane = bcast ? {W{mask_bit}} : data;

`ifdef CC_GATE_PARITY_EN
    // Even parity: the bit that makes the total count of ones even.
    assign par = ^lane;
`endif

endmodule
`default_nettype wire

// File: rtl/cc_chan_gate_seq.sv
`default_nettype none
// ============================================================================
// Module      : cc_chan_gate_seq
// Description : Sequential condition-code channel gate. Accepts one command
//               (mode bits, channel mask, beat count) and streams NCH gated
//               W-bit lanes per beat over a valid/ready output handshake.
//               Optional feature macro: CC_GATE_PARITY_EN (adds out_par).
// Ports       : clk, rst          - clock, synchronous active-high reset
//               en                - global enable, drop aborts a transfer
//               cmd_*             - command channel (valid/ready)
//               chan_data         - live lane inputs, sampled per beat
//               out_valid/ready   - output beat handshake
//               out_data          - registered gated lanes
//               out_par           - per-lane even parity (macro only)
//               busy, done, err   - status
// Revision    : 1.0 - initial release
// ============================================================================
module cc_chan_gate_seq
    import cc_gate_pkg::*;
#(
    parameter int NCH = 6,
    parameter int W   = 1,
    parameter int CW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_sel_i,
    input  logic             cmd_sel_k,
    input  logic             cmd_dir,
    input  logic [NCH-1:0]   cmd_mask,
    input  logic [CW-1:0]    cmd_beats,
    input  logic [NCH*W-1:0] chan_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NCH*W-1:0] out_data,
`ifdef CC_GATE_PARITY_EN
    output logic [NCH-1:0]   out_par,
`endif
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [CW-1:0] c_one = {{(CW-1){1'b0}}, 1'b1};

    cc_gate_state_e   r_state;
    logic             r_sel_i;
    logic             r_sel_k;
    logic             r_dir;
    logic [NCH-1:0]   r_mask;
    logic [CW-1:0]    r_beats;
    logic [CW-1:0]    r_count;

    logic             w_bcast;
    logic [NCH*W-1:0] w_lanes;
    logic             w_hs;
    logic             w_load;
    logic             w_last;

    assign w_bcast   = cc_bcast(r_sel_i, r_sel_k, r_dir);
    assign w_hs      = out_valid & out_ready;
    // A fresh beat may be loaded whenever the output register is empty or
    // is being emptied this cycle.
    assign w_load    = ~out_valid | w_hs;
    // Beats are non-zero once in XFER, so beats-1 never underflows.
    assign w_last    = (r_count == (r_beats - c_one));
    assign cmd_ready = (r_state == IDLE) & en;
    assign busy      = (r_state != IDLE);

`ifdef CC_GATE_PARITY_EN
    logic [NCH-1:0] w_par;
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        cc_gate_lane #(.W(W)) u_lane (
            .bcast    (w_bcast),
            .mask_bit (r_mask[c]),
            .data     (chan_data[c*W +: W]),
`ifdef CC_GATE_PARITY_EN
            .par      (w_par[c]),
`endif
            .lane     (w_lanes[c*W +: W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sel_i   <= 1'b0;
            r_sel_k   <= 1'b0;
            r_dir     <= 1'b0;
            r_mask    <= '0;
            r_beats   <= '0;
            r_count   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef CC_GATE_PARITY_EN
            out_par   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        r_sel_i <= cmd_sel_i;
                        r_sel_k <= cmd_sel_k;
                        r_dir   <= cmd_dir;
                        r_mask  <= cmd_mask;
                        r_beats <= cmd_beats;
                        r_count <= '0;
                        if (cmd_beats == '0) begin
                            err <= 1'b1;
                        end else begin
                            err     <= 1'b0;
                            r_state <= XFER;
                        end
                    end
                end
                XFER: begin
                    // Abort wins over completion, but a beat handshaking in
                    // the abort cycle has still been delivered.
                    if (!en) begin
                        if (w_hs) begin
                            r_count <= r_count + c_one;
                        end
                        out_valid <= 1'b0;
                        err       <= 1'b1;
                        r_state   <= IDLE;
                    end else if (w_hs && w_last) begin
                        r_count   <= r_count + c_one;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        r_state   <= DONE;
                    end else if (w_load) begin
                        if (w_hs) begin
                            r_count <= r_count + c_one;
                        end
                        out_data  <= w_lanes;
                        out_valid <= 1'b1;
`ifdef CC_GATE_PARITY_EN
                        out_par   <= w_par;
`endif
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
